// File: rtl/pixel_unpacker_pkg.sv
// pixel_unpacker_pkg: shared video geometry, byte-lane layout and phase type
package pixel_unpacker_pkg;
  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;
  localparam int PIX_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;
  function automatic int words_per_line(input int x_size);
    return 3 * x_size / 4;
  endfunction
endpackage

// File: rtl/pixel_unpacker_if.sv
// pixel_unpacker_if: packed-word input stream plus unpacked pixel output stream
interface pixel_unpacker_if;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tuser;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        err_sof;
  logic        err_eol;
  logic        err_keep;
  logic        frame_done;
  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tuser, s_tvalid, pix_ready,
    output s_tready, r, g, b, pix_valid, pix_sof, pix_eol, err_sof, err_eol, err_keep, frame_done
  );
  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tuser, s_tvalid, pix_ready,
    input  s_tready, r, g, b, pix_valid, pix_sof, pix_eol, err_sof, err_eol, err_keep, frame_done
  );
endinterface

// File: rtl/pixel_slot_reg.sv
// pixel_slot_reg: registered output pixel slot backed by one pending slot
module pixel_slot_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_pend_load,
  input  logic [W-1:0] i_pend_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_pend_valid
);
  logic         r_valid;
  logic         r_pend_valid;
  logic [W-1:0] r_data;
  logic [W-1:0] r_pend;
  // a load only happens when the output slot is free or leaving and pending is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_data       <= '0;
      r_pend       <= '0;
    end else if (i_load) begin
      r_valid      <= 1'b1;
      r_data       <= i_data;
      r_pend_valid <= i_pend_load;
      r_pend       <= i_pend_data;
    end else if (r_valid && i_ready) begin
      r_valid      <= r_pend_valid;
      r_pend_valid <= 1'b0;
      if (r_pend_valid) r_data <= r_pend;
    end
  end
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_pend_valid = r_pend_valid;
endmodule

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: unpacks 3 packed 32-bit words into 4 RGB888 pixels with framing checks
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  pixel_unpacker_if.slave   bus
);
  localparam int WPL = words_per_line(X_SIZE);
  localparam int XW  = $clog2(X_SIZE);
  localparam int YW  = $clog2(Y_SIZE);
  localparam int WW  = $clog2(WPL);
  localparam logic [XW-1:0] X_LAST  = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_SIZE - 1);
  localparam logic [WW-1:0] WX_LAST = WW'(WPL - 1);

  phase_t             r_phase;
  phase_t             w_phase;
  phase_t             w_phase_nxt;
  logic [23:0]        r_res;
  logic [23:0]        w_res_nxt;
  logic [PIX_W-1:0]   w_pix;
  logic [PIX_W-1:0]   w_out_pix;
  logic               w_load_pend;
  logic               w_pix_valid;
  logic               w_pend_valid;
  logic               w_word_fire;
  logic               w_pix_fire;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [WW-1:0]      r_wx;
  logic [YW-1:0]      r_wy;
  logic [WW-1:0]      w_wx;
  logic [YW-1:0]      w_wy;
  logic               r_err_sof;
  logic               r_err_eol;
  logic               r_err_keep;
  logic               r_frame_done;

  assign bus.s_tready = !w_pend_valid && (!w_pix_valid || bus.pix_ready);
  assign w_word_fire  = bus.s_tvalid && bus.s_tready;
  assign w_pix_fire   = w_pix_valid && bus.pix_ready;
  assign w_wx         = bus.s_tuser ? '0 : r_wx;
  assign w_wy         = bus.s_tuser ? '0 : r_wy;

  // phase register and byte residue carried between words of a group
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_phase <= PH0;
      r_res   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_res   <= w_res_nxt;
    end
  end

  // a frame-start word restarts the group at phase 0, dropping any residue
  always_comb begin
    w_phase     = bus.s_tuser ? PH0 : r_phase;
    w_phase_nxt = r_phase;
    w_res_nxt   = r_res;
    w_pix       = bus.s_tdata[23:0];
    w_load_pend = 1'b0;
    if (w_word_fire) begin
      case (w_phase)
        PH0: begin
          w_phase_nxt = PH1;
          w_res_nxt   = {16'h0, bus.s_tdata[31:24]};
        end
        PH1: begin
          w_phase_nxt = PH2;
          w_pix       = {bus.s_tdata[15:0], r_res[7:0]};
          w_res_nxt   = {bus.s_tdata[31:16], 8'h0};
        end
        default: begin
          w_phase_nxt = PH0;
          w_pix       = {bus.s_tdata[7:0], r_res[23:8]};
          w_load_pend = 1'b1;
        end
      endcase
    end
  end

  pixel_slot_reg #(.W(PIX_W)) u_slot (
    .clk          (aclk),
    .rst          (areset),
    .i_load       (w_word_fire),
    .i_data       (w_pix),
    .i_pend_load  (w_load_pend),
    .i_pend_data  (bus.s_tdata[31:8]),
    .i_ready      (bus.pix_ready),
    .o_valid      (w_pix_valid),
    .o_data       (w_out_pix),
    .o_pend_valid (w_pend_valid)
  );

  // input word/line position and sticky framing checks on every accepted word
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wx       <= '0;
      r_wy       <= '0;
      r_err_sof  <= 1'b0;
      r_err_eol  <= 1'b0;
      r_err_keep <= 1'b0;
    end else if (w_word_fire) begin
      r_wx       <= (w_wx == WX_LAST) ? '0 : w_wx + WW'(1);
      r_wy       <= (w_wx != WX_LAST) ? w_wy : (w_wy == Y_LAST) ? '0 : w_wy + YW'(1);
      r_err_sof  <= r_err_sof || (bus.s_tuser != (r_wx == '0 && r_wy == '0));
      r_err_eol  <= r_err_eol || (bus.s_tlast != (w_wx == WX_LAST));
      r_err_keep <= r_err_keep || (bus.s_tkeep != 4'hF);
    end
  end

  // output pixel coordinates; a frame-start word points them at the next pixel out
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pix_fire && r_x == X_LAST && r_y == Y_LAST;
      if (w_word_fire && bus.s_tuser) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_pix_fire) begin
        r_x <= (r_x == X_LAST) ? '0 : r_x + XW'(1);
        r_y <= (r_x != X_LAST) ? r_y : (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end
    end
  end

  assign bus.r          = w_out_pix[R_LSB +: 8];
  assign bus.g          = w_out_pix[G_LSB +: 8];
  assign bus.b          = w_out_pix[B_LSB +: 8];
  assign bus.pix_valid  = w_pix_valid;
  assign bus.pix_sof    = w_pix_valid && r_x == '0 && r_y == '0;
  assign bus.pix_eol    = w_pix_valid && r_x == X_LAST;
  assign bus.err_sof    = r_err_sof;
  assign bus.err_eol    = r_err_eol;
  assign bus.err_keep   = r_err_keep;
  assign bus.frame_done = r_frame_done;
endmodule
